// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the controller and the core under test.
// Define ARBITER_LOCK_EN to add bus_lock/bus_lock_owner, which restrict grants to one port.
module memory_bus_arbiter #(
  parameter int unsigned          BUS_WIDTH      = 32,
  parameter int unsigned          TIMEOUT_CYCLES = 360,
  parameter logic [BUS_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ctrl_read,
  input  logic                 ctrl_write,
  input  logic [BUS_WIDTH-1:0] ctrl_address,
  input  logic [BUS_WIDTH-1:0] ctrl_write_data,
  output logic [BUS_WIDTH-1:0] ctrl_read_data,
  output logic                 ctrl_response,
  output logic                 ctrl_busy,
  input  logic                 core_read,
  input  logic                 core_write,
  input  logic [BUS_WIDTH-1:0] core_address,
  input  logic [BUS_WIDTH-1:0] core_write_data,
  output logic [BUS_WIDTH-1:0] core_read_data,
  output logic                 core_response,
  output logic                 core_busy,
  output logic                 memory_read,
  output logic                 memory_write,
  output logic [BUS_WIDTH-1:0] memory_address,
  output logic [BUS_WIDTH-1:0] memory_write_data,
  input  logic [BUS_WIDTH-1:0] memory_read_data,
  input  logic                 memory_response,
  output logic                 owner,
  output logic                 timeout_error
`ifdef ARBITER_LOCK_EN
  ,
  input  logic                 bus_lock,
  input  logic                 bus_lock_owner
`endif
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  // Index 0 is the controller, index 1 the core.
  logic [1:0]                 rd_in, wr_in;
  logic [1:0][BUS_WIDTH-1:0]  addr_in, wdata_in;

  state_e                     state_q, state_d;
  logic [1:0]                 pend_q, pend_d;
  logic [1:0]                 is_wr_q, is_wr_d;
  logic [1:0][BUS_WIDTH-1:0]  addr_q, addr_d;
  logic [1:0][BUS_WIDTH-1:0]  wdata_q, wdata_d;
  logic [1:0][BUS_WIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]                 resp_q, resp_d;
  logic                       mem_rd_q, mem_rd_d;
  logic                       mem_wr_q, mem_wr_d;
  logic [BUS_WIDTH-1:0]       mem_addr_q, mem_addr_d;
  logic [BUS_WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
  logic                       owner_q, owner_d;
  logic                       last_q, last_d;
  logic                       timeout_q, timeout_d;
  logic [31:0]                cnt_q, cnt_d;
  logic [1:0]                 lock_mask, eligible;
  logic                       winner;

  assign rd_in    = {core_read, ctrl_read};
  assign wr_in    = {core_write, ctrl_write};
  assign addr_in  = {core_address, ctrl_address};
  assign wdata_in = {core_write_data, ctrl_write_data};

`ifdef ARBITER_LOCK_EN
  assign lock_mask = !bus_lock ? 2'b11 : (bus_lock_owner ? 2'b10 : 2'b01);
`else
  assign lock_mask = 2'b11;
`endif

  assign eligible = pend_q & lock_mask;
  // On a tie the port that did not win last time goes next.
  assign winner   = (eligible == 2'b11) ? ~last_q : eligible[1];

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    resp_d      = 2'b00;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    owner_d     = owner_q;
    last_d      = last_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;

    for (int i = 0; i < 2; i++) begin
      if (!pend_q[i] && (rd_in[i] || wr_in[i])) begin
        pend_d[i]  = 1'b1;
        is_wr_d[i] = wr_in[i];
        addr_d[i]  = addr_in[i];
        wdata_d[i] = wdata_in[i];
      end
    end

    unique case (state_q)
      StIdle: begin
        if (|eligible) begin
          mem_addr_d  = addr_q[winner];
          mem_wdata_d = wdata_q[winner];
          mem_rd_d    = ~is_wr_q[winner];
          mem_wr_d    = is_wr_q[winner];
          owner_d     = winner;
          last_d      = winner;
          cnt_d       = '0;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (memory_response) begin
          resp_d[owner_q] = 1'b1;
          if (!is_wr_q[owner_q]) rdata_d[owner_q] = memory_read_data;
          pend_d[owner_q] = 1'b0;
          state_d         = StIdle;
        end else if (cnt_q >= 32'(TIMEOUT_CYCLES - 1)) begin
          resp_d[owner_q]  = 1'b1;
          rdata_d[owner_q] = TIMEOUT_DATA;
          timeout_d        = 1'b1;
          pend_d[owner_q]  = 1'b0;
          state_d          = StIdle;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      is_wr_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ctrl_read_data    = rdata_q[0];
  assign core_read_data    = rdata_q[1];
  assign ctrl_response     = resp_q[0];
  assign core_response     = resp_q[1];
  assign ctrl_busy         = pend_q[0];
  assign core_busy         = pend_q[1];
  assign memory_read       = mem_rd_q;
  assign memory_write      = mem_wr_q;
  assign memory_address    = mem_addr_q;
  assign memory_write_data = mem_wdata_q;
  assign owner             = owner_q;
  assign timeout_error     = timeout_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the ports, the bus and a memory with random latency.
module tb_memory_bus_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] rd_in = '0, wr_in = '0;
  logic [1:0][W-1:0] a_in = '0, d_in = '0;
  logic [1:0][W-1:0] rdata;
  logic [1:0] resp, busy;
  logic memory_read, memory_write, memory_response = 1'b0;
  logic [W-1:0] memory_address, memory_write_data, memory_read_data = '0;
  logic owner, timeout_error;
`ifdef ARBITER_LOCK_EN
  logic bus_lock = 1'b0, bus_lock_owner = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  memory_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .ctrl_read(rd_in[0]), .ctrl_write(wr_in[0]), .ctrl_address(a_in[0]),
    .ctrl_write_data(d_in[0]), .ctrl_read_data(rdata[0]), .ctrl_response(resp[0]),
    .ctrl_busy(busy[0]),
    .core_read(rd_in[1]), .core_write(wr_in[1]), .core_address(a_in[1]),
    .core_write_data(d_in[1]), .core_read_data(rdata[1]), .core_response(resp[1]),
    .core_busy(busy[1]),
    .memory_read(memory_read), .memory_write(memory_write),
    .memory_address(memory_address), .memory_write_data(memory_write_data),
    .memory_read_data(memory_read_data), .memory_response(memory_response),
    .owner(owner), .timeout_error(timeout_error)
`ifdef ARBITER_LOCK_EN
    , .bus_lock(bus_lock), .bus_lock_owner(bus_lock_owner)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: after return, outputs show the new cycle and inputs apply to it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; rd_in = '0; wr_in = '0; memory_response = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic drain();
    rd_in = '0; wr_in = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      memory_response = memory_read | memory_write;
    end
    memory_response = 1'b0;
  endtask

  task automatic ctrl_read_txn(input logic [W-1:0] addr, input logic [W-1:0] data,
                               input string tag);
    rd_in[0] = 1'b1; a_in[0] = addr;
    step();
    rd_in[0] = 1'b0;
    check_eq({tag, "_busy"}, busy[0], 1);
    check_eq({tag, "_early_rd"}, memory_read, 0);
    step();
    check_eq({tag, "_mem_rd"}, memory_read, 1);
    check_eq({tag, "_mem_addr"}, memory_address, addr);
    check_eq({tag, "_owner"}, owner, 0);
    memory_response = 1'b1; memory_read_data = data;
    step();
    memory_response = 1'b0;
    check_eq({tag, "_resp"}, resp[0], 1);
    check_eq({tag, "_rdata"}, rdata[0], data);
    check_eq({tag, "_busy_clr"}, busy[0], 0);
    step();
    check_eq({tag, "_resp_pulse"}, resp[0], 0);
  endtask

  // Randomized traffic checked against a port/bus/memory transaction model.
  task automatic random_run(input int ncyc);
    bit pend[2], pwr[2];
    logic [W-1:0] paddr[2], pdata[2], rd_last[2];
    int preq[2];
    bit waiting = 0;
    int who = 0, last = 1, due = 0;
    bit exp_owner = 0;
    logic [W-1:0] rd_drv = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; pwr[i] = 0; paddr[i] = '0; pdata[i] = '0; rd_last[i] = '0; preq[i] = 0;
    end
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      bit resp_now, idle_prev, exp_pulse;
      bit [1:0] elig, exp_resp;
      int win;
      int a;
      step();
      rd_in = '0; wr_in = '0; memory_response = 1'b0;
      resp_now = waiting && (c == due);
      idle_prev = !waiting;
      exp_resp = '0;
      if (resp_now) begin
        if (!pwr[who]) rd_last[who] = rd_drv;
        pend[who] = 0;
        waiting = 0;
        exp_resp[who] = 1'b1;
      end
      // A buffered request needs a full idle cycle before its memory pulse.
      for (int i = 0; i < 2; i++) elig[i] = pend[i] && (preq[i] <= c - 2);
      exp_pulse = idle_prev && (elig != 0);
      win = 0;
      if (exp_pulse) begin
        win = (elig == 2'b11) ? 1 - last : (elig[1] ? 1 : 0);
        last = win; who = win; exp_owner = win[0]; waiting = 1;
        due = c + 1 + int'($urandom_range(0, 3));
      end
      check_eq("rnd_mem_rd", memory_read, exp_pulse && !pwr[win]);
      check_eq("rnd_mem_wr", memory_write, exp_pulse && pwr[win]);
      if (exp_pulse) begin
        check_eq("rnd_mem_addr", memory_address, paddr[win]);
        check_eq("rnd_mem_wdata", memory_write_data, pdata[win]);
      end
      check_eq("rnd_owner", owner, exp_owner);
      check_eq("rnd_busy", busy, {pend[1], pend[0]});
      check_eq("rnd_resp", resp, exp_resp);
      check_eq("rnd_timeout", timeout_error, 0);
      if (resp_now) check_eq("rnd_rdata", rdata[who], rd_last[who]);
      if (waiting && c == due - 1) begin
        rd_drv = $urandom;
        memory_response = 1'b1; memory_read_data = rd_drv;
      end else if (!waiting && ($urandom_range(0, 7) == 0)) begin
        memory_response = 1'b1; memory_read_data = $urandom;
      end
      for (int i = 0; i < 2; i++) begin
        a = int'($urandom_range(0, 9));
        rd_in[i] = (a < 2) || (a == 4);
        wr_in[i] = (a == 3) || (a == 4);
        a_in[i] = $urandom; d_in[i] = $urandom;
        if (!pend[i] && (rd_in[i] || wr_in[i])) begin
          pend[i] = 1; pwr[i] = wr_in[i]; paddr[i] = a_in[i]; pdata[i] = d_in[i]; preq[i] = c;
        end
      end
    end
    drain();
  endtask

  initial begin
    int n;
    reset = 1'b0;
    step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_resp", resp, 0);
    check_eq("rst_mem", {memory_read, memory_write, owner, timeout_error}, 0);
    check_eq("rst_addr", memory_address, 0);
    check_eq("rst_rdata0", rdata[0], 0);
    reset = 1'b1;

    ctrl_read_txn(32'h10, 32'h12345678, "rd1");

    // Simultaneous writes after reset: ctrl first, core right after one idle cycle.
    do_reset();
    wr_in = 2'b11; a_in[0] = 32'h20; d_in[0] = 32'hAA; a_in[1] = 32'h30; d_in[1] = 32'hBB;
    step();
    wr_in = '0;
    check_eq("tie_busy", busy, 2'b11);
    step();
    check_eq("tie_wr0", memory_write, 1);
    check_eq("tie_addr0", memory_address, 32'h20);
    check_eq("tie_data0", memory_write_data, 32'hAA);
    check_eq("tie_owner0", owner, 0);
    memory_response = 1'b1;
    step();
    memory_response = 1'b0;
    check_eq("tie_resp0", resp, 2'b01);
    check_eq("tie_busy1", busy, 2'b10);
    check_eq("tie_gap", memory_write, 0);
    step();
    check_eq("tie_wr1", memory_write, 1);
    check_eq("tie_addr1", memory_address, 32'h30);
    check_eq("tie_data1", memory_write_data, 32'hBB);
    check_eq("tie_owner1", owner, 1);
    memory_response = 1'b1;
    step();
    memory_response = 1'b0;
    check_eq("tie_resp1", resp, 2'b10);
    check_eq("tie_busy_end", busy, 0);
    check_eq("tie_wr_keeps_rdata", rdata[1], 0);

    // Continuous requests from both ports alternate grants.
    do_reset();
    rd_in = 2'b11; a_in[0] = 32'h100; a_in[1] = 32'h200;
    n = 0;
    for (int i = 0; i < 200 && n < 8; i++) begin
      step();
      memory_response = memory_read;
      if (memory_read) begin
        check_eq("rr_owner", owner, n % 2);
        n++;
      end
    end
    check_eq("rr_count", n, 8);
    drain();

    // Hung memory: abort after the timeout window.
    do_reset();
    rd_in[0] = 1'b1; a_in[0] = 32'h40;
    step();
    rd_in[0] = 1'b0;
    step();
    check_eq("to_mem_rd", memory_read, 1);
    for (int i = 0; i < 359; i++) step();
    check_eq("to_not_yet", resp[0], 0);
    step();
    check_eq("to_resp", resp[0], 1);
    check_eq("to_rdata", rdata[0], 32'hDEADBEEF);
    check_eq("to_err", timeout_error, 1);
    step();
    check_eq("to_err_pulse", timeout_error, 0);
    check_eq("to_busy", busy[0], 0);

    // Reset in the middle of a core access.
    rd_in[1] = 1'b1; a_in[1] = 32'h50;
    step();
    rd_in[1] = 1'b0;
    step();
    check_eq("rw_mem_rd", memory_read, 1);
    check_eq("rw_owner", owner, 1);
    step();
    reset = 1'b0;
    #1;
    check_eq("rw_busy", busy, 0);
    check_eq("rw_owner0", owner, 0);
    check_eq("rw_addr0", memory_address, 0);
    step();
    reset = 1'b1; memory_response = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      memory_response = 1'b0;
      check_eq("rw_no_resp", resp, 0);
    end
    ctrl_read_txn(32'h60, 32'hCAFEF00D, "rd2");

`ifdef ARBITER_LOCK_EN
    do_reset();
    bus_lock = 1'b1; bus_lock_owner = 1'b0;
    rd_in[1] = 1'b1; a_in[1] = 32'h70;
    step();
    rd_in[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("lk_busy", busy[1], 1);
      check_eq("lk_no_rd", memory_read, 0);
    end
    bus_lock = 1'b0;
    n = 0;
    for (int i = 0; i < 2 && n == 0; i++) begin
      step();
      if (memory_read) n = 1;
    end
    check_eq("lk_issue", n, 1);
    check_eq("lk_addr", memory_address, 32'h70);
    drain();
`endif

    random_run(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shares the single memory bus between two requesters: the controller interpreter (ctrl) and the core under test (core).
- Each port has a one-entry request buffer, so single-cycle read/write pulses are never lost.
- Grants are round-robin; each issued access is a one-cycle pulse on the memory side.
- A response timeout protects the controller from a hung memory.
- The block replaces the static controller/core mux selection that the interpreter drives today.

Parameters:
- BUS_WIDTH, 32, width of address and data on all ports.
- TIMEOUT_CYCLES, 360, cycles to wait for memory_response before aborting an access.
- TIMEOUT_DATA, 32'hDEADBEEF, read data returned on an aborted access.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ctrl_read  in  1  controller read request pulse.
- ctrl_write  in  1  controller write request pulse.
- ctrl_address  in  BUS_WIDTH  controller address, sampled with the request.
- ctrl_write_data  in  BUS_WIDTH  controller write data, sampled with the request.
- ctrl_read_data  out  BUS_WIDTH  read data, valid while ctrl_response=1.
- ctrl_response  out  1  one-cycle completion pulse to the controller.
- ctrl_busy  out  1  controller request buffer occupied.
- core_read, core_write, core_address, core_write_data, core_read_data, core_response, core_busy: same as the ctrl_* ports, for the core.
- memory_read  out  1  one-cycle read pulse to memory.
- memory_write  out  1  one-cycle write pulse to memory.
- memory_address  out  BUS_WIDTH  address to memory.
- memory_write_data  out  BUS_WIDTH  write data to memory.
- memory_read_data  in  BUS_WIDTH  read data from memory.
- memory_response  in  1  memory completion pulse.
- owner  out  1  current or last bus owner: 0 = ctrl, 1 = core.
- timeout_error  out  1  one-cycle pulse when an access is aborted.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; both request buffers empty; state IDLE.
  - Internal last_grant = core, so ctrl wins the first tie.
  - Reset during WAIT abandons the access with no response pulse.
- Capture:
  - While a port's busy=0, a rising-edge-sampled read or write latches {op, address, write_data} and sets busy.
  - While busy=1, new requests on that port are ignored.
  - read and write both high in the same cycle: the request is a write; the read is dropped.
- States:
  - IDLE: if either buffer is pending, pick the winner. If only one is pending, that port wins. If both are pending, the port other than last_grant wins. At the same edge, register memory_address/memory_write_data from the winner's buffer, pulse memory_read or memory_write for one cycle, set owner and last_grant, clear the timeout counter, and go to WAIT.
  - WAIT: memory_response is sampled from the first cycle memory_read/memory_write is high onward.
    - On memory_response=1: the owner's response pulses for one cycle, its read_data = memory_read_data (reads only; writes leave read_data unchanged), its buffer clears (busy=0), and the state returns to IDLE.
    - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without a response: owner's response=1, read_data=TIMEOUT_DATA, timeout_error=1 (each one cycle), buffer clears, state returns to IDLE.
- Latency: request in cycle t → memory pulse in cycle t+2. With memory_response in t+2, the requester's response is in cycle t+3.
- Re-arbitration: at least one IDLE cycle separates consecutive accesses.
- Buffer reuse: a port may issue a new request in the cycle after its response pulse, since busy is already 0.
- Other outputs: memory_address/memory_write_data hold their last value in IDLE; owner holds its last value.
- A memory_response arriving in IDLE is ignored.
- The timeout counter is 32 bits and saturates; it does not wrap.

Optional Feature:
- Macro: ARBITER_LOCK_EN.
- When defined, two inputs are added:
  - bus_lock (1 bit).
  - bus_lock_owner (1 bit; 0 = ctrl, 1 = core).
- While bus_lock=1, IDLE grants only bus_lock_owner. The other port's request stays buffered (busy=1) until the lock drops.
- A lock asserted during WAIT does not abort the access in flight.
- When not defined, the ports are absent and arbitration is pure round-robin.

Test Plan:
- ctrl_read pulse, addr 0x10 in cycle t; memory returns 0x12345678 with response in t+2 → memory_read=1 at t+2 with address 0x10; ctrl_response=1 and ctrl_read_data=0x12345678 at t+3; owner=0.
- ctrl_write (0x20, 0xAA) and core_write (0x30, 0xBB) in the same cycle after reset → ctrl access issued first, then core; owner 0 then 1.
- Both ports re-request continuously, 4 accesses each → grants alternate ctrl, core, ctrl, core.
- ctrl_read with memory_response held 0 → after 360 WAIT cycles: ctrl_response=1, ctrl_read_data=0xDEADBEEF, timeout_error=1; ctrl_busy=0 the next cycle.
- reset driven low during WAIT of a core read → all outputs 0 immediately, no core_response; the next ctrl request is served normally.
- ARBITER_LOCK_EN, bus_lock=1, owner=ctrl, core_read pending → core stays busy with no memory_read for 10 cycles; the core access issues within 2 cycles of bus_lock dropping.
